// File: rtl/red_pitaya_slew_pkg.sv
// Shared definitions for the PID output slew/clamp stage: state encoding,
// register map offsets and width-dependent reset values.
package red_pitaya_slew_pkg;

    localparam int DW_DEF   = 14;
    localparam int DIVW_DEF = 16;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HOLD   = 2'd2
    } slew_state_t;

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_LO     = 5'h04;
    localparam logic [4:0] ADDR_HI     = 5'h08;
    localparam logic [4:0] ADDR_STEP   = 5'h0C;
    localparam logic [4:0] ADDR_DIV    = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;

    // Reset values as 32-bit patterns; callers keep the low dw bits.
    function automatic logic [31:0] lo_rst_val(input int dw);
        return 32'hFFFF_FFFF << (dw - 1);
    endfunction

    function automatic logic [31:0] hi_rst_val(input int dw);
        return (32'h1 << (dw - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] step_rst_val(input int dw);
        return (32'h1 << dw) - 32'h1;
    endfunction

endpackage

// File: rtl/red_pitaya_slew_core.sv
// Combinational clamp + rate-limit datapath: next output value from the
// current output, the raw command and the limit registers.
module red_pitaya_slew_core #(
    parameter int DW = 14
) (
    input  logic signed [DW-1:0] i_dat,
    input  logic signed [DW-1:0] i_cur,
    input  logic signed [DW-1:0] i_lo,
    input  logic signed [DW-1:0] i_hi,
    input  logic        [DW-1:0] i_step,
    output logic signed [DW-1:0] o_next,
    output logic                 o_sat_hi,
    output logic                 o_sat_lo,
    output logic                 o_slewing
);

    logic signed [DW-1:0] w_tgt;
    logic signed [DW:0]   w_diff;
    logic        [DW:0]   w_abs;
    logic        [DW-1:0] w_stepped;

    assign o_sat_hi = i_dat > i_hi;
    assign o_sat_lo = i_dat < i_lo;

    // A crossed window (LO > HI) always resolves to LO.
    always_comb begin
        w_tgt = i_dat;
        if (i_lo > i_hi)
            w_tgt = i_lo;
        else if (o_sat_hi)
            w_tgt = i_hi;
        else if (o_sat_lo)
            w_tgt = i_lo;
    end

    // One extra bit so the full-scale difference cannot wrap.
    assign w_diff    = {w_tgt[DW-1], w_tgt} - {i_cur[DW-1], i_cur};
    assign w_abs     = w_diff[DW] ? -w_diff : w_diff;
    assign o_slewing = w_abs > {1'b0, i_step};

    // Only used when |diff| > STEP, so the result lies between cur and tgt.
    assign w_stepped = w_diff[DW] ? (i_cur - i_step) : (i_cur + i_step);
    assign o_next    = o_slewing ? w_stepped : w_tgt;

endmodule

// File: rtl/red_pitaya_pid_slew.sv
// PID-to-DAC conditioning: programmable clamp window and per-tick step limit,
// with sys-bus configuration/status and a BYPASS/TRACK/HOLD mode machine.
module red_pitaya_pid_slew
    import red_pitaya_slew_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int DIVW = DIVW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] dat_i,
    output logic signed [DW-1:0] dat_o,
    input  logic [31:0]          sys_addr,
    input  logic [31:0]          sys_wdata,
    input  logic                 sys_wen,
    input  logic                 sys_ren,
    output logic [31:0]          sys_rdata,
    output logic                 sys_err,
    output logic                 sys_ack
);

    localparam logic [31:0] LO_RST32   = lo_rst_val(DW);
    localparam logic [31:0] HI_RST32   = hi_rst_val(DW);
    localparam logic [31:0] STEP_RST32 = step_rst_val(DW);

    logic                 r_enable;
    logic                 r_hold;
    logic signed [DW-1:0] r_lo;
    logic signed [DW-1:0] r_hi;
    logic        [DW-1:0] r_step;
    logic      [DIVW-1:0] r_div;
    logic      [DIVW-1:0] r_cnt;
    slew_state_t          r_state;
    logic signed [DW-1:0] r_dat;
    logic                 r_sat_hi;
    logic                 r_sat_lo;
    logic                 r_slewing;
    logic                 r_ack;
    logic [31:0]          r_rdata;

    logic [4:0]           w_addr;
    logic                 w_tick;
    logic                 w_track_tick;
    logic                 w_wr_ctrl;
    logic                 w_wr_div;
    logic                 w_clr;
    logic [31:0]          w_rd_val;
    logic signed [DW-1:0] w_next;
    logic                 w_sat_hi;
    logic                 w_sat_lo;
    logic                 w_slewing;
    logic                 w_unused;

    assign w_addr       = sys_addr[4:0];
    assign w_tick       = (r_cnt == r_div);
    assign w_track_tick = (r_state == ST_TRACK) && w_tick;
    assign w_wr_ctrl    = sys_wen && (w_addr == ADDR_CTRL);
    assign w_wr_div     = sys_wen && (w_addr == ADDR_DIV);
    assign w_clr        = w_wr_ctrl && sys_wdata[2];
    assign w_unused     = ^{sys_addr, sys_wdata};

    red_pitaya_slew_core #(.DW(DW)) u_core (
        .i_dat     (dat_i),
        .i_cur     (r_dat),
        .i_lo      (r_lo),
        .i_hi      (r_hi),
        .i_step    (r_step),
        .o_next    (w_next),
        .o_sat_hi  (w_sat_hi),
        .o_sat_lo  (w_sat_lo),
        .o_slewing (w_slewing)
    );

    always_comb begin
        w_rd_val = '0;
        case (w_addr)
            ADDR_CTRL:   w_rd_val = {30'd0, r_hold, r_enable};
            ADDR_LO:     w_rd_val = {{(32-DW){r_lo[DW-1]}}, r_lo};
            ADDR_HI:     w_rd_val = {{(32-DW){r_hi[DW-1]}}, r_hi};
            ADDR_STEP:   w_rd_val = {{(32-DW){1'b0}}, r_step};
            ADDR_DIV:    w_rd_val = {{(32-DIVW){1'b0}}, r_div};
            ADDR_STATUS: w_rd_val = {27'd0, r_state, r_slewing, r_sat_lo, r_sat_hi};
            default:     w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable  <= 1'b0;
            r_hold    <= 1'b0;
            r_lo      <= LO_RST32[DW-1:0];
            r_hi      <= HI_RST32[DW-1:0];
            r_step    <= STEP_RST32[DW-1:0];
            r_div     <= '0;
            r_cnt     <= '0;
            r_state   <= ST_BYPASS;
            r_dat     <= '0;
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
            r_slewing <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack   <= sys_wen | sys_ren;
            r_rdata <= sys_ren ? w_rd_val : '0;

            if (w_wr_ctrl) begin
                r_enable <= sys_wdata[0];
                r_hold   <= sys_wdata[1];
            end
            if (sys_wen && (w_addr == ADDR_LO))   r_lo   <= sys_wdata[DW-1:0];
            if (sys_wen && (w_addr == ADDR_HI))   r_hi   <= sys_wdata[DW-1:0];
            if (sys_wen && (w_addr == ADDR_STEP)) r_step <= sys_wdata[DW-1:0];
            if (w_wr_div)                         r_div  <= sys_wdata[DIVW-1:0];

            r_cnt <= (w_wr_div || w_tick) ? '0 : r_cnt + 1'b1;

            // A flag being set in the same cycle as a clear survives.
            r_sat_hi <= (r_sat_hi & ~w_clr) | (w_track_tick & w_sat_hi);
            r_sat_lo <= (r_sat_lo & ~w_clr) | (w_track_tick & w_sat_lo);
            if (w_track_tick)
                r_slewing <= w_slewing;

            case (r_state)
                ST_BYPASS: begin
                    r_dat <= dat_i;
                    if (r_enable)
                        r_state <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_tick)
                        r_dat <= w_next;
                    if (!r_enable)
                        r_state <= ST_BYPASS;
                    else if (r_hold)
                        r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!r_enable)
                        r_state <= ST_BYPASS;
                    else if (!r_hold)
                        r_state <= ST_TRACK;
                end
                default: r_state <= ST_BYPASS;
            endcase
        end
    end

    assign dat_o     = r_dat;
    assign sys_ack   = r_ack;
    assign sys_rdata = r_rdata;
    assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_pid_slew.sv
// Bench for red_pitaya_pid_slew: cycle-level reference model feeding an
// expected queue, with an independent monitor comparing every cycle.
module tb_red_pitaya_pid_slew;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] dat_i;
    logic [13:0] dat_o;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    red_pitaya_pid_slew dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Expected entry: {ack, check_rdata, rdata[31:0], dat_o[13:0]}
    logic [47:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [13:0] tb_dat = '0;

    int m_en, m_hold, m_lo, m_hi, m_step, m_div, m_cnt, m_state, m_dat;
    bit m_shi, m_slo, m_slew;

    function automatic int sx14(input logic [13:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_step(input bit r, input logic [13:0] d, input bit wen, input bit ren,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [47:0] e);
        int di, tgt, diff, adiff, ndat, nstate;
        bit tick, set_hi, set_lo, clr;
        logic [4:0] a;
        logic [31:0] v;
        if (r) begin
            m_en = 0; m_hold = 0; m_lo = -8192; m_hi = 8191; m_step = 16383;
            m_div = 0; m_cnt = 0; m_state = 0; m_dat = 0;
            m_shi = 0; m_slo = 0; m_slew = 0;
            e = {1'b0, 1'b1, 32'd0, 14'd0};
            return;
        end
        di = sx14(d);
        a  = addr[4:0];
        case (a)
            5'h00: v = {30'd0, 1'(m_hold), 1'(m_en)};
            5'h04: v = m_lo;
            5'h08: v = m_hi;
            5'h0C: v = m_step;
            5'h10: v = m_div;
            5'h14: v = {27'd0, 2'(m_state), m_slew, m_slo, m_shi};
            default: v = 32'd0;
        endcase
        tick   = (m_cnt == m_div);
        set_hi = 0;
        set_lo = 0;
        ndat   = m_dat;
        if (m_state == 0) begin
            ndat = di;
        end else if (m_state == 1 && tick) begin
            set_hi = di > m_hi;
            set_lo = di < m_lo;
            if (m_lo > m_hi)   tgt = m_lo;
            else if (set_hi)   tgt = m_hi;
            else if (set_lo)   tgt = m_lo;
            else               tgt = di;
            diff  = tgt - m_dat;
            adiff = (diff < 0) ? -diff : diff;
            if (adiff <= m_step) begin
                ndat = tgt;
                m_slew = 0;
            end else begin
                ndat = m_dat + ((diff > 0) ? m_step : -m_step);
                m_slew = 1;
            end
        end
        clr   = wen && a == 5'h00 && wd[2];
        m_shi = (m_shi && !clr) || set_hi;
        m_slo = (m_slo && !clr) || set_lo;
        if (m_en == 0)        nstate = 0;
        else if (m_state == 0) nstate = 1;
        else if (m_hold != 0) nstate = 2;
        else                  nstate = 1;
        m_state = nstate;
        m_dat   = ndat;
        m_cnt   = ((wen && a == 5'h10) || tick) ? 0 : m_cnt + 1;
        if (wen) begin
            case (a)
                5'h00: begin m_en = int'(wd[0]); m_hold = int'(wd[1]); end
                5'h04: m_lo = sx14(wd[13:0]);
                5'h08: m_hi = sx14(wd[13:0]);
                5'h0C: m_step = int'(wd[13:0]);
                5'h10: m_div = int'(wd[15:0]);
                default: ;
            endcase
        end
        e = {wen | ren, ren, ren ? v : 32'd0, 14'(m_dat)};
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit r, input bit wen, input bit ren,
                       input logic [31:0] addr, input logic [31:0] wd);
        logic [47:0] e;
        @(negedge clk);
        rst = r; sys_wen = wen; sys_ren = ren; sys_addr = addr; sys_wdata = wd; dat_i = tb_dat;
        model_step(r, tb_dat, wen, ren, addr, wd, e);
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [47:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (dat_o !== e[13:0]) begin
                    n_err++;
                    $display("FAIL dat_o t=%0t got %0d exp %0d", $time, $signed(dat_o), $signed(e[13:0]));
                end
                n_vec++;
                if (sys_ack !== e[47]) begin
                    n_err++;
                    $display("FAIL sys_ack t=%0t got %b exp %b", $time, sys_ack, e[47]);
                end
                n_vec++;
                if (sys_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL sys_err t=%0t got %b exp 0", $time, sys_err);
                end
                if (e[46]) begin
                    n_vec++;
                    if (sys_rdata !== e[45:14]) begin
                        n_err++;
                        $display("FAIL sys_rdata t=%0t got %h exp %h", $time, sys_rdata, e[45:14]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, d;
        int sel;
        rst = 1'b1; sys_wen = 1'b0; sys_ren = 1'b0; sys_addr = '0; sys_wdata = '0; dat_i = '0;

        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) rd(32'(i * 4));
        rd(32'h18);

        // bypass follows input with one cycle of latency
        tb_dat = 14'd5000;
        idle(3);
        rd(32'h14);

        // ramp 0 -> 1000 in steps of 100
        tb_dat = 14'd0;
        idle(2);
        wr(32'h0C, 32'd100);
        wr(32'h00, 32'd1);
        idle(3);
        tb_dat = 14'd1000;
        idle(4);
        rd(32'h14);
        idle(10);
        rd(32'h14);

        // clamp at HI, sticky flag survives a clear while still saturating
        wr(32'h08, 32'd2000);
        wr(32'h04, 32'hFFFF_F830);
        wr(32'h0C, 32'h3FFF);
        tb_dat = 14'd7000;
        idle(3);
        rd(32'h14);
        wr(32'h00, 32'd5);
        rd(32'h14);
        rd(32'h00);

        // divided tick, then hold mid-ramp
        tb_dat = 14'd0;
        idle(3);
        wr(32'h0C, 32'd10);
        wr(32'h10, 32'd4);
        tb_dat = 14'h3F9C; // -100
        idle(22);
        wr(32'h00, 32'd3);
        idle(12);
        rd(32'h14);
        wr(32'h00, 32'd1);
        idle(25);

        // crossed window and zero step
        wr(32'h10, 32'd0);
        wr(32'h04, 32'd500);
        wr(32'h08, 32'hFFFF_FE0C);
        idle(4);
        rd(32'h14);
        wr(32'h0C, 32'd0);
        tb_dat = 14'd3000;
        idle(4);
        rd(32'h14);

        // reset mid-ramp with a read pending
        wr(32'h04, 32'hFFFF_E000);
        wr(32'h08, 32'h1FFF);
        wr(32'h0C, 32'd5);
        idle(5);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        begin
            logic [47:0] e;
            rst = 1'b1; sys_ren = 1'b1; sys_addr = 32'h14; dat_i = tb_dat;
            model_step(1'b1, tb_dat, 1'b0, 1'b1, 32'h14, 32'd0, e);
            exp_q.push_back(e);
        end
        for (int i = 0; i < 6; i++) rd(32'(i * 4));

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) tb_dat = 14'($urandom_range(0, 16383));
            sel = $urandom_range(0, 15);
            if (sel < 2) begin
                a = 32'($urandom_range(0, 4) * 4);
                case (a[4:0])
                    5'h00: d = 32'($urandom_range(0, 7));
                    5'h0C: d = 32'($urandom_range(0, 600));
                    5'h10: d = 32'($urandom_range(0, 5));
                    default: d = 32'($urandom_range(0, 16383));
                endcase
                if (a[4:0] == 5'h00 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                wr(a, d);
            end else if (sel < 4) begin
                rd(32'($urandom_range(0, 7) * 4));
            end else if (sel == 4 && $urandom_range(0, 30) == 0) begin
                cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            end else begin
                idle(1);
            end
        end
        idle(2);

        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
